reel_hex_driver: RTL and testbench

REEL_HEX_DRIVER -- requirements
Module: reel_hex_driver

---
 rtl/reel_hex_driver.sv | 168 ++++++++++++++++
 tb/tb_reel_hex_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reel_hex_driver.sv
// Slot-machine style reel driver: spinning decimal digits that stop one at a time,
// with a 7-segment decode and an optional win blink on the final result.
module reel_hex_driver #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned SPIN_DIV   = 2500000,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spin_start,
    input  logic                    stop_req,
    input  logic                    win,
    output logic [4*NUM_DIGITS-1:0] reel_val,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    all_stopped,
    output logic                    stop_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SPIN_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   spinning_q, spinning_d;
    logic [IDX_W-1:0]        stop_idx_q, stop_idx_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic                    blank_q, blank_d;
    logic [4*NUM_DIGITS-1:0] reel_q, reel_d;
    logic                    all_stopped_q, all_stopped_d;
    logic                    stop_done_q, stop_done_d;

    logic                    tick;
    logic [NUM_DIGITS-1:0]   stop_mask;
    logic [NUM_DIGITS-1:0]   adv;
    logic [3:0]              sum;
    logic                    blank_c;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            spinning_q    <= '0;
            stop_idx_q    <= '0;
            pre_q         <= '0;
            blk_q         <= '0;
            blank_q       <= 1'b0;
            reel_q        <= '0;
            all_stopped_q <= 1'b1;
            stop_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            spinning_q    <= spinning_d;
            stop_idx_q    <= stop_idx_d;
            pre_q         <= pre_d;
            blk_q         <= blk_d;
            blank_q       <= blank_d;
            reel_q        <= reel_d;
            all_stopped_q <= all_stopped_d;
            stop_done_q   <= stop_done_d;
        end
    end

    // Next-state, prescaler, stop sequencing, blink and digit advance
    always_comb begin
        state_d     = state_q;
        spinning_d  = spinning_q;
        stop_idx_d  = stop_idx_q;
        pre_d       = pre_q;
        blk_d       = blk_q;
        blank_d     = blank_q;
        reel_d      = reel_q;
        stop_done_d = 1'b0;
        tick        = 1'b0;
        stop_mask   = '0;
        adv         = '0;
        sum         = '0;

        case (state_q)
            IDLE, DONE: begin
                if (spin_start) begin
                    state_d    = SPIN;
                    spinning_d = '1;
                    stop_idx_d = '0;
                    pre_d      = '0;
                    blk_d      = '0;
                    blank_d    = 1'b0;
                end else if (state_q == DONE) begin
                    if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
                        blk_d   = '0;
                        blank_d = ~blank_q;
                    end else begin
                        blk_d = blk_q + BLK_W'(1);
                    end
                end
            end
            SPIN: begin
                tick  = (pre_q == PRE_W'(SPIN_DIV - 1));
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
                if (stop_req) begin
                    stop_mask[stop_idx_q] = 1'b1;
                    spinning_d = spinning_q & ~stop_mask;
                    if (stop_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        state_d     = DONE;
                        stop_done_d = 1'b1;
                        blk_d       = '0;
                        blank_d     = 1'b0;
                    end else begin
                        stop_idx_d = stop_idx_q + IDX_W'(1);
                    end
                end
                if (tick) begin
                    adv = spinning_q & ~stop_mask;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Digit i steps by (i mod 3)+1; a freshly stopped digit is masked out of adv
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            sum = reel_q[4*i +: 4] + 4'((i % 3) + 1);
            if (adv[i]) begin
                reel_d[4*i +: 4] = (sum >= 4'd10) ? sum - 4'd10 : sum;
            end
        end

        all_stopped_d = (state_d != SPIN);
    end

    assign blank_c = (state_q == DONE) && win && blank_q;

    // Zero-latency segment decode of the registered digits
    always_comb begin
        hex_out = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            hex_out[7*i +: 7] = blank_c ? 7'b1111111 : seg7(reel_q[4*i +: 4]);
        end
    end

    assign reel_val    = reel_q;
    assign all_stopped = all_stopped_q;
    assign stop_done   = stop_done_q;

endmodule

// File: tb/tb_reel_hex_driver.sv
// Bench for reel_hex_driver: directed vector table, hand sequences for tick/stop and
// blink timing, then random traffic checked against a cycle-count based reference model.
module tb_reel_hex_driver;

    localparam int N  = 3;
    localparam int SD = 4;
    localparam int BD = 8;

    localparam logic [6:0] GLYPH [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          spin_start = 1'b0;
    logic          stop_req = 1'b0;
    logic          win = 1'b0;
    logic [4*N-1:0] reel_val;
    logic [7*N-1:0] hex_out;
    logic          all_stopped;
    logic          stop_done;

    int checks = 0;
    int errors = 0;

    reel_hex_driver #(.NUM_DIGITS(N), .SPIN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .spin_start(spin_start), .stop_req(stop_req), .win(win),
        .reel_val(reel_val), .hex_out(hex_out), .all_stopped(all_stopped), .stop_done(stop_done)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=spin 2=done, time counted in edges since entry
    int m_mode = 0;
    int m_t = 0;
    int m_dt = 0;
    int m_nstop = 0;
    int m_pulse = 0;
    int m_val [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic ss, input logic sr);
        bit tk;
        if (r) begin
            m_mode = 0; m_t = 0; m_dt = 0; m_nstop = 0; m_pulse = 0;
            for (int i = 0; i < N; i++) m_val[i] = 0;
        end else begin
            m_pulse = 0;
            if (m_mode != 1) begin
                if (ss) begin
                    m_mode = 1; m_t = 0; m_nstop = 0;
                end else if (m_mode == 2) begin
                    m_dt++;
                end
            end else begin
                tk = ((m_t % SD) == SD - 1);
                for (int i = 0; i < N; i++)
                    if (tk && i >= m_nstop && !(sr && i == m_nstop))
                        m_val[i] = (m_val[i] + (i % 3) + 1) % 10;
                if (sr) begin
                    m_nstop++;
                    if (m_nstop == N) begin
                        m_mode = 2; m_dt = 0; m_pulse = 1;
                    end
                end
                m_t++;
            end
        end
    endtask

    function automatic logic [4*N-1:0] model_reel();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_val[i]);
        return v;
    endfunction

    function automatic logic [7*N-1:0] model_hex(input logic w);
        logic [7*N-1:0] h;
        bit blank;
        blank = (m_mode == 2) && w && (((m_dt / BD) % 2) == 1);
        for (int i = 0; i < N; i++) h[7*i +: 7] = blank ? 7'b1111111 : GLYPH[m_val[i]];
        return h;
    endfunction

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later
    task automatic cyc(input logic r, input logic ss, input logic sr, input logic w);
        rst = r; spin_start = ss; stop_req = sr; win = w;
        @(posedge clk);
        model_step(r, ss, sr);
        #1;
        chk("model_reel", 32'(reel_val), 32'(model_reel()));
        chk("model_hex", 32'(hex_out), 32'(model_hex(w)));
        chk("model_all_stopped", 32'(all_stopped), 32'(m_mode != 1));
        chk("model_stop_done", 32'(stop_done), 32'(m_pulse));
    endtask

    typedef struct {
        logic r, ss, sr, w;
        int reps;
        logic [11:0] reel;
        logic as, sd;
    } vec_t;

    vec_t tbl [21];
    logic [7*N-1:0] vis;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  12'h000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  12'h000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3,  12'h000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  12'h321, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 36, 12'h000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  12'h000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  12'h320, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  12'h320, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  12'h620, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  12'h620, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  12'h620, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3,  12'h620, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  12'h620, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2,  12'h620, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  12'h000, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  12'h000, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  12'h321, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  12'h321, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  12'h321, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  12'h000, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  12'h000, 1'b1, 1'b0};

        for (int i = 0; i < 21; i++) begin
            for (int k = 0; k < tbl[i].reps; k++) cyc(tbl[i].r, tbl[i].ss, tbl[i].sr, tbl[i].w);
            chk($sformatf("vec%0d_reel", i), 32'(reel_val), 32'(tbl[i].reel));
            chk($sformatf("vec%0d_all_stopped", i), 32'(all_stopped), 32'(tbl[i].as));
            chk($sformatf("vec%0d_stop_done", i), 32'(stop_done), 32'(tbl[i].sd));
            if (i == 0) chk("reset_hex", 32'(hex_out), 32'({3{7'b1000000}}));
        end

        // Stop request landing on a tick with digit0 at 3
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (15) cyc(0, 0, 0, 0);
        chk("pre_tick_stop_reel", 32'(reel_val), 32'(12'h963));
        cyc(0, 0, 1, 0);
        chk("tick_stop_reel", 32'(reel_val), 32'(12'h283));
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("done_entry_pulse", 32'(stop_done), 32'(1));
        chk("done_entry_reel", 32'(reel_val), 32'(12'h283));

        // Blink timing after entering DONE with win held high
        vis = {GLYPH[2], GLYPH[8], GLYPH[3]};
        chk("blink_c0", 32'(hex_out), 32'(vis));
        for (int j = 1; j < 20; j++) begin
            cyc(0, 0, 0, 1);
            chk($sformatf("blink_c%0d", j), 32'(hex_out),
                32'((j >= 8 && j < 16) ? {(7*N){1'b1}} : vis));
        end
        for (int j = 20; j < 32; j++) begin
            cyc(0, 0, 0, 0);
            chk($sformatf("steady_c%0d", j), 32'(hex_out), 32'(vis));
        end

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                ($urandom_range(5) == 0), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
